// File: rtl/scale_mode_apply_pkg.sv
// Shared video package: mode encodings, key codes, size shifts, FSM states.
// Helpers map key codes to modes, modes to LEDs and modes to sizes.
package scale_mode_apply_pkg;

  localparam logic [1:0] MODE_QUARTER = 2'd0;
  localparam logic [1:0] MODE_HALF    = 2'd1;
  localparam logic [1:0] MODE_FULL    = 2'd2;

  localparam logic [2:0] KEY_QUARTER = 3'b001;
  localparam logic [2:0] KEY_HALF    = 3'b010;
  localparam logic [2:0] KEY_FULL    = 3'b100;

  localparam int SHIFT_QUARTER = 2;
  localparam int SHIFT_HALF    = 1;
  localparam int SHIFT_FULL    = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_t;

  function automatic int mode_shift(
    input logic [1:0] m
  );
    case (m)
      MODE_QUARTER: return SHIFT_QUARTER;
      MODE_HALF:    return SHIFT_HALF;
      default:      return SHIFT_FULL;
    endcase
  endfunction

  function automatic logic [11:0] scale_dim(
    input int         full,
    input logic [1:0] m
  );
    return 12'(full >> mode_shift(m));
  endfunction

  function automatic logic [1:0] key_to_mode(
    input logic [2:0] k
  );
    logic [1:0] m;
    m = MODE_FULL;
    unique case (1'b1)
      k[0]:    m = MODE_QUARTER;
      k[1]:    m = MODE_HALF;
      k[2]:    m = MODE_FULL;
      default: m = MODE_FULL;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] mode_to_led(
    input logic [1:0] m
  );
    return 3'b001 << m;
  endfunction

endpackage

// File: rtl/scale_mode_apply_sync_edge_det.sv
// Two-flop synchronizer plus delay flop; registered one-cycle rising pulse.
// Ports: sys_clk, sys_rst_n, din (async level), rise (sync pulse).
module sync_edge_det (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic rise
);

  logic meta;
  logic sync;
  logic dly;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      dly  <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      dly  <= sync;
      rise <= sync & ~dly;
    end
  end

endmodule

// File: rtl/scale_mode_apply.sv
// Applies key-requested scale mode at the next frame start or on timeout.
// Ports: change_en/vs_in in; mode_idx, sizes, param_load, busy, led out.
module scale_mode_apply
  import scale_mode_apply_pkg::*;
#(
  parameter int H_MAX       = 1280,
  parameter int V_MAX       = 720,
  parameter int TIMEOUT_CYC = 2_500_000,
  parameter int BLINK_CYC   = 12_500_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [2:0]  change_en,
  input  logic        vs_in,
  output logic [1:0]  mode_idx,
  output logic [11:0] out_h_size,
  output logic [11:0] out_v_size,
  output logic        param_load,
  output logic        busy,
  output logic [2:0]  led
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] B_LOAD = BW'(BLINK_CYC);

  state_t        state;
  logic [1:0]    target;
  logic [1:0]    tgt_n;
  logic [1:0]    req_mode;
  logic [2:0]    req_held;
  logic          fs;
  logic          go;
  logic          apply_now;
  logic [TW-1:0] t_cnt;
  logic [BW-1:0] b_cnt;

  sync_edge_det u_vs_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (vs_in),
    .rise      (fs)
  );

  // Invalid (non one-hot) codes leave the last valid request in place.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      req_held <= KEY_FULL;
    end else if ($onehot(change_en)) begin
      req_held <= change_en;
    end
  end

  assign req_mode = key_to_mode(req_held);
  assign go       = fs | (t_cnt == T_LAST);

  always_comb begin
    tgt_n = target;
    if (req_mode != mode_idx) tgt_n = req_mode;
  end

  assign apply_now = (state == ST_PENDING)
                   && (req_mode != mode_idx)
                   && go;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      target     <= MODE_FULL;
      mode_idx   <= MODE_FULL;
      out_h_size <= 12'(H_MAX);
      out_v_size <= 12'(V_MAX);
      param_load <= 1'b0;
      busy       <= 1'b0;
      t_cnt      <= '0;
    end else begin
      param_load <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_mode != mode_idx) begin
            state  <= ST_PENDING;
            target <= req_mode;
            busy   <= 1'b1;
            t_cnt  <= '0;
          end
        end
        ST_PENDING: begin
          if (t_cnt != '1) t_cnt <= t_cnt + TW'(1);
          if (req_mode == mode_idx) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            target <= tgt_n;
            if (go) begin
              state      <= ST_APPLY;
              mode_idx   <= tgt_n;
              out_h_size <= scale_dim(H_MAX, tgt_n);
              out_v_size <= scale_dim(V_MAX, tgt_n);
              param_load <= 1'b1;
            end
          end
        end
        ST_APPLY: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // LED goes dark for BLINK_CYC cycles from each apply, restarting on reapply.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      b_cnt <= '0;
      led   <= KEY_FULL;
    end else if (apply_now) begin
      b_cnt <= B_LOAD;
      led   <= 3'b000;
    end else if (b_cnt != '0) begin
      b_cnt <= b_cnt - BW'(1);
      led   <= (b_cnt > BW'(1)) ? 3'b000 : mode_to_led(mode_idx);
    end else begin
      led   <= mode_to_led(mode_idx);
    end
  end

endmodule

// File: tb/tb_scale_mode_apply.sv
// Bench for scale_mode_apply: directed scenarios then random traffic.
// Every cycle is compared against a behavioural model of the mode rules.
module tb_scale_mode_apply;

  localparam int H = 1280;
  localparam int V = 720;
  localparam int T = 100;
  localparam int B = 50;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [2:0]  change_en = 3'b100;
  logic        vs_in = 1'b0;
  logic [1:0]  mode_idx;
  logic [11:0] out_h_size;
  logic [11:0] out_v_size;
  logic        param_load;
  logic        busy;
  logic [2:0]  led;

  always #5 sys_clk = ~sys_clk;

  scale_mode_apply #(
    .H_MAX       (H),
    .V_MAX       (V),
    .TIMEOUT_CYC (T),
    .BLINK_CYC   (B)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .change_en  (change_en),
    .vs_in      (vs_in),
    .mode_idx   (mode_idx),
    .out_h_size (out_h_size),
    .out_v_size (out_v_size),
    .param_load (param_load),
    .busy       (busy),
    .led        (led)
  );

  int tests = 0;
  int fails = 0;
  int ncyc = 0;
  int pl_count = 0;

  int m_mode;
  int m_req;
  int m_pcnt;
  int m_off;
  int m_led;
  bit m_pend;
  bit m_apply;
  bit m_busy;
  bit m_pl;
  bit vsh[$];

  function automatic int key_mode(input logic [2:0] k);
    if (k == 3'b001) return 0;
    if (k == 3'b010) return 1;
    if (k == 3'b100) return 2;
    return -1;
  endfunction

  function automatic int size_of(input int full, input int m);
    if (m == 0) return full / 4;
    if (m == 1) return full / 2;
    return full;
  endfunction

  function automatic void model_reset();
    m_mode  = 2;
    m_req   = 2;
    m_pcnt  = 0;
    m_off   = 0;
    m_led   = 4;
    m_pend  = 0;
    m_apply = 0;
    m_busy  = 0;
    m_pl    = 0;
    vsh     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  // A vs_in rise seen at clock n lets the mode change at clock n+3.
  function automatic void model_step(input logic [2:0] ci, input logic cv);
    bit fs;
    int req;
    vsh.push_front(cv);
    void'(vsh.pop_back());
    fs  = vsh[3] && !vsh[4];
    req = m_req;
    if (key_mode(ci) >= 0) m_req = key_mode(ci);
    m_pl = 0;
    if (m_apply) begin
      m_apply = 0;
      m_busy  = 0;
    end else if (!m_pend) begin
      if (req != m_mode) begin
        m_pend = 1;
        m_busy = 1;
        m_pcnt = 0;
      end
    end else if (req == m_mode) begin
      m_pend = 0;
      m_busy = 0;
    end else if (fs || m_pcnt == T - 1) begin
      m_mode  = req;
      m_pl    = 1;
      m_apply = 1;
      m_pend  = 0;
    end else begin
      m_pcnt++;
    end
    if (m_pl) begin
      m_led = 0;
      m_off = B - 1;
    end else if (m_off > 0) begin
      m_led = 0;
      m_off--;
    end else begin
      m_led = 1 << m_mode;
    end
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("mode_idx", 32'(mode_idx), m_mode);
    check("out_h_size", 32'(out_h_size), size_of(H, m_mode));
    check("out_v_size", 32'(out_v_size), size_of(V, m_mode));
    check("param_load", 32'(param_load), 32'(m_pl));
    check("busy", 32'(busy), 32'(m_busy));
    check("led", 32'(led), m_led);
  endtask

  task automatic tick();
    logic [2:0] ci;
    logic       cv;
    ci = change_en;
    cv = vs_in;
    @(posedge sys_clk);
    #1;
    ncyc++;
    if (sys_rst_n) model_step(ci, cv);
    else model_reset();
    if (param_load === 1'b1) pl_count++;
    check_all();
  endtask

  initial begin
    int t0;
    int t1;
    int n;
    int base;

    model_reset();
    change_en = 3'b100;
    vs_in     = 1'b0;
    sys_rst_n = 1'b0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    repeat (20) tick();
    check("idle_no_load", pl_count, 0);
    check("idle_led", 32'(led), 4);

    change_en = 3'b010;
    repeat (5) tick();
    check("cancel_busy_set", 32'(busy), 1);
    change_en = 3'b100;
    repeat (10) tick();
    check("cancel_busy_clr", 32'(busy), 0);
    check("cancel_no_load", pl_count, 0);
    check("cancel_h", 32'(out_h_size), 1280);

    change_en = 3'b011;
    repeat (10) tick();
    change_en = 3'b000;
    repeat (10) tick();
    check("invalid_busy", 32'(busy), 0);
    check("invalid_mode", 32'(mode_idx), 2);
    check("invalid_no_load", pl_count, 0);

    change_en = 3'b010;
    t0 = -1000;
    for (int i = 0; i < 10 && t0 < 0; i++) begin
      tick();
      if (busy === 1'b1) t0 = ncyc;
    end
    t1 = -1;
    for (int i = 0; i < 300 && t1 < 0; i++) begin
      tick();
      if (param_load === 1'b1) t1 = ncyc;
    end
    check("timeout_latency", t1 - t0, 100);
    check("timeout_h", 32'(out_h_size), 640);
    check("timeout_v", 32'(out_v_size), 360);
    repeat (60) tick();
    check("timeout_led", 32'(led), 2);

    change_en = 3'b001;
    repeat (50) tick();
    check("frame_busy", 32'(busy), 1);
    vs_in = 1'b1;
    t0 = ncyc;
    t1 = -1;
    for (int i = 0; i < 20 && t1 < 0; i++) begin
      tick();
      if (param_load === 1'b1) t1 = ncyc;
    end
    check("frame_latency", t1 - t0, 4);
    check("frame_h", 32'(out_h_size), 320);
    check("frame_v", 32'(out_v_size), 180);
    n = 1;
    for (int i = 0; i < 200 && led === 3'b000; i++) begin
      tick();
      if (led === 3'b000) n++;
    end
    check("blink_len", n, B);
    check("blink_led_after", 32'(led), 1);
    vs_in = 1'b0;
    repeat (5) tick();

    change_en = 3'b010;
    repeat (10) tick();
    check("rst_pend_busy", 32'(busy), 1);
    #2;
    sys_rst_n = 1'b0;
    change_en = 3'b100;
    #1;
    model_reset();
    check_all();
    repeat (3) tick();
    sys_rst_n = 1'b1;
    vs_in = 1'b1;
    base = pl_count;
    repeat (30) tick();
    check("rst_no_load", pl_count - base, 0);
    check("rst_mode", 32'(mode_idx), 2);
    check("rst_led", 32'(led), 4);
    vs_in = 1'b0;
    repeat (5) tick();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) change_en = 3'($urandom_range(7));
      if ($urandom_range(59) == 0) vs_in = ~vs_in;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scale_mode_apply.md
SCALE_MODE_APPLY -- requirements
Module: scale_mode_apply

Interface
REQ-001 Parameter H_MAX, default 1280: full-scale output width in pixels.
REQ-002 Parameter V_MAX, default 720: full-scale output height in lines.
REQ-003 Parameter TIMEOUT_CYC, default 2_500_000: maximum cycles to wait for a frame boundary before forcing the apply.
REQ-004 Parameter BLINK_CYC, default 12_500_000: length of the LED-off acknowledge flash, in cycles.
REQ-005 Ports:
- sys_clk  in  1  system clock (50 MHz); the only clock.
- sys_rst_n  in  1  reset; asynchronous, active-low.
- change_en  in  3  one-hot mode request from the key controller (001 = quarter, 010 = half, 100 = full).
- vs_in  in  1  video vertical sync (active-high); asynchronous to sys_clk.
- mode_idx  out  2  active mode (0 = quarter, 1 = half, 2 = full).
- out_h_size  out  12  active output width.
- out_v_size  out  12  active output height.
- param_load  out  1  one-cycle strobe; the scaler latches the size outputs on it.
- busy  out  1  high while a mode change is pending.
- led  out  3  one-hot active-mode indicator.

Function
REQ-006 vs_in shall pass through a 2-flop synchronizer plus one delay flop; frame start (fs) = synchronized rising edge, one cycle wide.
REQ-007 change_en shall be registered once; it is valid only if exactly one bit is set. Values 000, 011, 101, 110 and 111 shall be ignored, and the last valid request held.
REQ-008 FSM states: IDLE, PENDING, APPLY.
REQ-009 IDLE -> PENDING when the valid registered request differs from mode_idx; target <= request; busy <= 1.
REQ-010 In PENDING, a new valid request different from target shall update target without restarting the timeout counter.
REQ-011 In PENDING, a request equal to mode_idx shall return the FSM to IDLE; no param_load is issued and busy returns to 0.
REQ-012 PENDING -> APPLY on fs, or when the timeout counter reaches TIMEOUT_CYC-1, whichever occurs first. If both occur in the same cycle, a single apply is performed.
REQ-013 APPLY lasts one cycle. On entry, update mode_idx/out_h_size/out_v_size to target; param_load = 1 for that cycle only; then go to IDLE with busy = 0.
REQ-014 Size table:
- mode 0: H_MAX/4 x V_MAX/4.
- mode 1: H_MAX/2 x V_MAX/2.
- mode 2: H_MAX x V_MAX.
- Computed by right shift and truncated to 12 bits.
REQ-015 The timeout counter shall clear on entry to PENDING, increment each PENDING cycle, and saturate; it shall not wrap.
REQ-016 The size outputs shall never change except in the APPLY cycle, so that they are stable across every frame.
REQ-017 led = one-hot of mode_idx, except led = 000 for BLINK_CYC cycles after each APPLY. A new APPLY during the blink restarts the blink.
REQ-018 Latency: param_load is high exactly 1 cycle after the clock edge at which fs is first high while in PENDING.

Reset
REQ-019 Asynchronous assert, synchronous release of effect. On reset:
- FSM = IDLE.
- mode_idx = 2; out_h_size = H_MAX; out_v_size = V_MAX.
- param_load = 0; busy = 0; led = 100.
- Synchronizer flops and counters = 0.
- Held request = 100.
REQ-020 Reset asserted mid-PENDING shall discard target; no param_load shall follow release.

Structure
REQ-021 Mode encodings, the size table shifts, and the FSM state encodings shall live in the shared video package alongside the key controller constants.
REQ-022 The vsync synchronizer/edge detector shall be one sub-module, sync_edge_det, reusable for hs/de.

Verification
REQ-023 Reset release with change_en=100 and no vs_in -> mode_idx=2, 1280x720, param_load never asserted, led=100.
REQ-024 change_en 100->001, then vs_in rising 1000 cycles later -> busy=1 until apply; param_load single pulse 4 cycles after the vs_in edge (2 sync + 1 edge + 1); size 320x180; led=000 for BLINK_CYC then 001.
REQ-025 change_en 100->010->100 before any vs_in edge -> return to IDLE, no param_load, sizes unchanged at 1280x720.
REQ-026 change_en 100->010 with vs_in held low (TIMEOUT_CYC=100 in bench) -> param_load at PENDING cycle 100; size 640x360.
REQ-027 change_en=011 and 000 applied -> ignored, busy stays 0, outputs unchanged.
REQ-028 Reset pulsed while PENDING, then vs_in edge -> no param_load; outputs at reset values.
